// File: rtl/hexd_pkg.sv
// rtl/hexd_pkg.sv - shared types and constants for the hex display controller
package hexd_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW   = 2'b01,
    BLANK  = 2'b10,
    SCROLL = 2'b11
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7.sv
// rtl/seg7.sv - hex nibble to active-low 7-segment glyph, segs = {g,f,e,d,c,b,a}
module seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    case (nibble)
      4'h0:    segs = 7'h40;
      4'h1:    segs = 7'h79;
      4'h2:    segs = 7'h24;
      4'h3:    segs = 7'h30;
      4'h4:    segs = 7'h19;
      4'h5:    segs = 7'h12;
      4'h6:    segs = 7'h02;
      4'h7:    segs = 7'h78;
      4'h8:    segs = 7'h00;
      4'h9:    segs = 7'h10;
      4'hA:    segs = 7'h08;
      4'hB:    segs = 7'h03;
      4'hC:    segs = 7'h46;
      4'hD:    segs = 7'h21;
      4'hE:    segs = 7'h06;
      default: segs = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_disp_ctrl.sv
// rtl/hex_disp_ctrl.sv - multi-digit hex display controller with static, blink and scroll-in modes
// Define HEXD_LZB_EN to blank leading zero digits while showing a value.
module hex_disp_ctrl
  import hexd_pkg::*;
#(
  parameter int NDIG     = 6,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic [7*NDIG-1:0] hex_segs,
  output logic              busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(NDIG + 1);

  state_t            state, state_nx;
  mode_t             mode_q;
  logic [4*NDIG-1:0] data_q;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     shifted;
  logic              accept, tick;

  logic [4*NDIG-1:0] disp_word;
  logic [NDIG-1:0]   blank;
  logic [7*NDIG-1:0] glyphs, segs_nx;
`ifdef HEXD_LZB_EN
  logic              lead;
`endif

  assign in_ready = (state != SCROLL);
  assign busy     = (state == SCROLL);
  assign accept   = in_valid && in_ready;
  assign tick     = (state != IDLE) && (cnt == CW'(TICK_DIV - 1));

  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = (in_mode == MODE_SCROLL) ? SCROLL : SHOW;
    end else if (tick) begin
      case (state)
        SHOW:    if (mode_q == MODE_BLINK) state_nx = BLANK;
        BLANK:   state_nx = SHOW;
        SCROLL:  if (shifted == SW'(NDIG - 1)) state_nx = SHOW;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      mode_q   <= MODE_STATIC;
      data_q   <= '0;
      cnt      <= '0;
      shifted  <= '0;
      hex_segs <= {NDIG{SEG_BLANK}};
    end else begin
      state    <= state_nx;
      hex_segs <= segs_nx;
      if (accept) begin
        data_q  <= in_data;
        mode_q  <= mode_t'(in_mode);
        cnt     <= '0;
        shifted <= '0;
      end else begin
        if (state != IDLE) cnt <= tick ? '0 : cnt + 1'b1;
        if (tick && state == SCROLL) shifted <= shifted + 1'b1;
      end
    end
  end

  // During scroll the top `shifted` nibbles sit right-justified; unfilled digits stay dark.
  always_comb begin
    disp_word = data_q;
    blank     = '0;
`ifdef HEXD_LZB_EN
    lead      = 1'b1;
`endif
    case (state)
      IDLE, BLANK: blank = '1;
      SCROLL: begin
        disp_word = data_q >> (4 * (NDIG - int'(shifted)));
        for (int k = 0; k < NDIG; k++) blank[k] = (k >= int'(shifted));
      end
      default: begin
`ifdef HEXD_LZB_EN
        for (int k = NDIG - 1; k > 0; k--) begin
          lead     = lead && (data_q[4*k +: 4] == 4'h0);
          blank[k] = lead;
        end
`endif
      end
    endcase
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    seg7 u_seg7 (
      .nibble (disp_word[4*k +: 4]),
      .segs   (glyphs[7*k +: 7])
    );
    assign segs_nx[7*k +: 7] = blank[k] ? SEG_BLANK : glyphs[7*k +: 7];
  end

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// tb/tb_hex_disp_ctrl.sv - self-checking bench: vector table, directed sequences, random vs reference model
module tb_hex_disp_ctrl;

  localparam int NDIG     = 6;
  localparam int TICK_DIV = 4;
  localparam logic [41:0] ALL_BLANK = '1;
  localparam logic [47:0] SPACES    = "      ";

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [1:0]  in_mode;
  logic [41:0] hex_segs;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time since last accept plus the latched request.
  bit          m_idle  = 1'b1;
  logic [23:0] m_val   = '0;
  logic [1:0]  m_mode  = '0;
  int          m_since = 0;
  logic [41:0] m_segs  = '1;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  mode;
    logic [47:0] text;
  } vec_t;
  vec_t vecs[6];

  hex_disp_ctrl #(.NDIG(NDIG), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .hex_segs (hex_segs),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(logic [7:0] c);
    string      on;
    logic [6:0] hi = '0;
    case (c)
      "0": on = "abcdef";  "1": on = "bc";      "2": on = "abdeg";   "3": on = "abcdg";
      "4": on = "bcfg";    "5": on = "acdfg";   "6": on = "acdefg";  "7": on = "abc";
      "8": on = "abcdefg"; "9": on = "abcdfg";  "A": on = "abcefg";  "b": on = "cdefg";
      "C": on = "adef";    "d": on = "bcdeg";   "E": on = "adefg";   "F": on = "aefg";
      default: on = "";
    endcase
    for (int i = 0; i < on.len(); i++) hi[on[i] - 8'd97] = 1'b1;
    return ~hi;
  endfunction

  function automatic logic [7:0] hexchar(logic [3:0] n);
    string hx = "0123456789AbCdEF";
    return hx[n];
  endfunction

  // Byte k of a text is the character on digit k (digit 0 rightmost).
  function automatic logic [41:0] text_segs(logic [47:0] t);
    logic [41:0] s;
    for (int k = 0; k < NDIG; k++) s[7*k +: 7] = glyph(t[8*k +: 8]);
    return s;
  endfunction

  function automatic logic [47:0] render(logic [23:0] v);
    logic [47:0] t;
    for (int k = 0; k < NDIG; k++) t[8*k +: 8] = hexchar(v[4*k +: 4]);
`ifdef HEXD_LZB_EN
    for (int k = NDIG - 1; k > 0; k--) begin
      if (v[4*k +: 4] != 4'h0) break;
      t[8*k +: 8] = " ";
    end
`endif
    return t;
  endfunction

  function automatic logic [41:0] m_disp();
    logic [41:0] r;
    logic [47:0] t;
    int          n;
    r = ALL_BLANK;
    if (!m_idle) begin
      if (m_mode == 2'b01) begin
        if ((m_since / TICK_DIV) % 2 == 0) r = text_segs(render(m_val));
      end else if (m_mode == 2'b10) begin
        n = m_since / TICK_DIV;
        if (n >= NDIG) begin
          r = text_segs(render(m_val));
        end else begin
          t = SPACES;
          for (int k = 0; k < n; k++) t[8*k +: 8] = hexchar(m_val[4*(k + NDIG - n) +: 4]);
          r = text_segs(t);
        end
      end else begin
        r = text_segs(render(m_val));
      end
    end
    return r;
  endfunction

  function automatic bit m_busy();
    return !m_idle && m_mode == 2'b10 && m_since < NDIG * TICK_DIV;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: advance the model with the inputs now applied, then compare after the edge.
  task automatic step();
    logic [41:0] nsegs;
    bit          ready;
    nsegs = m_disp();
    ready = !m_busy();
    if (!reset_n) begin
      m_idle = 1'b1; m_val = '0; m_mode = '0; m_since = 0;
      nsegs  = ALL_BLANK;
    end else if (in_valid && ready) begin
      m_idle = 1'b0; m_val = in_data; m_mode = in_mode; m_since = 0;
    end else if (!m_idle) begin
      m_since++;
    end
    m_segs = nsegs;
    @(posedge clk);
    #1;
    check("hex_segs", 64'(hex_segs), 64'(m_segs));
    check("busy",     64'(busy),     64'(m_busy()));
    check("in_ready", 64'(in_ready), 64'(!m_busy()));
  endtask

  task automatic expect_text(string name, logic [47:0] t);
    check(name, 64'(hex_segs), 64'(text_segs(t)));
  endtask

  initial begin
    vecs[0] = '{24'h12AB3F, 2'b00, "12Ab3F"};
    vecs[1] = '{24'hFEDCBA, 2'b01, "FEdCbA"};
    vecs[2] = '{24'h100000, 2'b00, "100000"};
`ifdef HEXD_LZB_EN
    vecs[3] = '{24'h000042, 2'b00, "    42"};
    vecs[4] = '{24'h000000, 2'b11, "     0"};
    vecs[5] = '{24'h098765, 2'b11, " 98765"};
`else
    vecs[3] = '{24'h000042, 2'b00, "000042"};
    vecs[4] = '{24'h000000, 2'b11, "000000"};
    vecs[5] = '{24'h098765, 2'b11, "098765"};
`endif

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
    step();
    step();
    check("reset_segs",  64'(hex_segs), 64'(ALL_BLANK));
    check("reset_busy",  64'(busy),     64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);

    // First vector is offered on the very first edge with reset released.
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_mode = vecs[i].mode;
      step();
      in_valid = 1'b0;
      step();
      expect_text($sformatf("vec%0d", i), vecs[i].text);
      check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
    end

    // Blink, then a fresh blink request accepted while blanked.
    in_valid = 1'b1; in_data = 24'h888888; in_mode = 2'b01;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) expect_text("blink_lit", "888888");
      if (k == 6) expect_text("blink_dark", SPACES);
    end
    in_valid = 1'b1; in_data = 24'hABCDEF; in_mode = 2'b01;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) expect_text("reblink_first", "AbCdEF");
      if (k == 4) expect_text("reblink_last_lit", "AbCdEF");
      if (k == 5) expect_text("reblink_dark", SPACES);
    end

    // Scroll-in with a competing request held throughout.
    in_valid = 1'b1; in_data = 24'h123456; in_mode = 2'b10;
    step();
    check("scroll_busy", 64'(busy), 64'd1);
    in_data = 24'h654321; in_mode = 2'b00;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 4)  expect_text("scroll_n0", SPACES);
      if (k == 5)  expect_text("scroll_n1", "     1");
      if (k == 9)  expect_text("scroll_n2", "    12");
      if (k == 23) check("scroll_busy_late", 64'(busy), 64'd1);
      if (k == 24) check("scroll_done_busy", 64'(busy), 64'd0);
      if (k == 25) expect_text("scroll_full", "123456");
      if (k == 26) expect_text("held_taken", "654321");
    end
    in_valid = 1'b0;
    step();

    // Reset pulse in the middle of a scroll.
    in_valid = 1'b1; in_data = 24'hABC123; in_mode = 2'b10;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 14; k++) step();
    reset_n = 1'b0;
    step();
    check("midreset_segs",  64'(hex_segs), 64'(ALL_BLANK));
    check("midreset_busy",  64'(busy),     64'd0);
    check("midreset_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    step();
    step();
    expect_text("after_reset_idle", SPACES);

    for (int i = 0; i < 1500; i++) begin
      logic [23:0] mask;
      case ($urandom_range(0, 2))
        0:       mask = 24'hFFFFFF;
        1:       mask = 24'h0000FF;
        default: mask = 24'h00000F;
      endcase
      reset_n  = ($urandom_range(0, 149) != 0);
      in_valid = ($urandom_range(0, 9) == 0);
      in_data  = 24'($urandom) & mask;
      in_mode  = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
